// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the RV32I register file write port.
// Collects results from the load/store unit and the ALU into an in-order
// circular buffer, drains one register write per cycle, and offers
// combinational bypass of pending results to the two decode read ports.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   lsu_valid/ready/addr/data         load result producer (priority on last slot)
//   alu_valid/ready/addr/data         ALU result producer
//   RegWriteControl/Addr, RegDataIn   register file write port (head entry)
//   rd_addr1/2                        decode read addresses
//   byp_hit1/2, byp_data1/2           youngest pending result for each read address
//   count, full, empty                occupancy status
module regfile_writeback_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [ADDR_W-1:0]         lsu_addr,
  input  logic [DATA_W-1:0]         lsu_data,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      RegWriteControl,
  output logic [ADDR_W-1:0]         RegWriteAddr,
  output logic [DATA_W-1:0]         RegDataIn,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      byp_hit1,
  output logic [DATA_W-1:0]         byp_data1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data2,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [CNT_W-1:0]  free;
  logic              lsu_push;
  logic              alu_push;
  logic              pop;
  logic [PTR_W-1:0]  alu_slot;
  logic [PTR_W-1:0]  byp_idx;

  // Handshake: free space is measured before any same-cycle pop.
  always_comb begin
    free      = CNT_W'(DEPTH) - count;
    lsu_ready = (free >= CNT_W'(1));
    alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !lsu_valid);
    // Writes to x0 complete the handshake but are not stored.
    lsu_push  = lsu_valid && lsu_ready && (lsu_addr != '0);
    alu_push  = alu_valid && alu_ready && (alu_addr != '0);
    pop       = (count != '0);
    // ALU is younger: it lands behind the LSU entry when both are stored.
    alu_slot  = tail + PTR_W'(lsu_push);
  end

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (lsu_push) valid_q[tail]     <= 1'b1;
      if (alu_push) valid_q[alu_slot] <= 1'b1;
      tail  <= tail + PTR_W'(lsu_push) + PTR_W'(alu_push);
      count <= count + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clock) begin
    if (lsu_push) begin
      addr_mem[tail] <= lsu_addr;
      data_mem[tail] <= lsu_data;
    end
    if (alu_push) begin
      addr_mem[alu_slot] <= alu_addr;
      data_mem[alu_slot] <= alu_data;
    end
  end

  // Register file write port driven straight from the head entry.
  always_comb begin
    RegWriteControl = pop;
    RegWriteAddr    = pop ? addr_mem[head] : '0;
    RegDataIn       = pop ? data_mem[head] : '0;
    full            = (count == CNT_W'(DEPTH));
    empty           = (count == '0);
  end

  // Bypass: scan oldest to youngest so the last match wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    byp_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = head + PTR_W'(i);
      if (valid_q[byp_idx] && (rd_addr1 != '0) && (addr_mem[byp_idx] == rd_addr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_mem[byp_idx];
      end
      if (valid_q[byp_idx] && (rd_addr2 != '0) && (addr_mem[byp_idx] == rd_addr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_mem[byp_idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue.
module tb_regfile_writeback_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        RegWriteControl;
  logic [4:0]  RegWriteAddr;
  logic [31:0] RegDataIn;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic        byp_hit2;
  logic [31:0] byp_data2;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .RegWriteControl(RegWriteControl), .RegWriteAddr(RegWriteAddr), .RegDataIn(RegDataIn),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle combinational outputs.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lsu_valid = v; lsu_addr = a; lsu_data = d;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v; alu_addr = a; alu_data = d;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
    check({tag, "_we"},   32'(RegWriteControl), 32'(we));
    check({tag, "_addr"}, 32'(RegWriteAddr),    32'(a));
    check({tag, "_data"}, RegDataIn,            d);
  endtask

  // A write is never issued to x0.
  always @(negedge clock) begin
    if (!reset && RegWriteControl)
      check("x0_never_written", 32'(RegWriteAddr != 5'd0), 32'd1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check_port("rst_port", 1'b0, 5'd0, 32'd0);
    check("rst_byp1", 32'(byp_hit1), 0);
    check("rst_lsu_ready", 32'(lsu_ready), 1);
    check("rst_alu_ready", 32'(alu_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    step();

    // 1: single ALU write, one cycle to the port, then drained
    drive_alu(1'b1, 5'd1, 32'd897);
    #1;
    check("t1_alu_ready", 32'(alu_ready), 1);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    rd_addr1 = 5'd1;
    #1;
    check("t1_count", 32'(count), 1);
    check_port("t1_port", 1'b1, 5'd1, 32'd897);
    check("t1_byp_hit", 32'(byp_hit1), 1);
    check("t1_byp_data", byp_data1, 32'd897);
    step();
    check("t1_empty", 32'(empty), 1);
    check_port("t1_idle", 1'b0, 5'd0, 32'd0);
    check("t1_byp_gone", 32'(byp_hit1), 0);

    // 2: dual push, LSU entry older than ALU entry
    drive_lsu(1'b1, 5'd2, 32'd666);
    drive_alu(1'b1, 5'd3, 32'd5);
    step();
    drive_lsu(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    #1;
    check("t2_count", 32'(count), 2);
    check_port("t2_first", 1'b1, 5'd2, 32'd666);
    step();
    check("t2_count_b", 32'(count), 1);
    check_port("t2_second", 1'b1, 5'd3, 32'd5);
    step();
    check("t2_empty", 32'(empty), 1);

    // 4: bypass returns youngest of two entries for the same register
    drive_lsu(1'b1, 5'd5, 32'd10);
    drive_alu(1'b1, 5'd5, 32'd20);
    step();
    drive_lsu(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd0;
    #1;
    check("t4_hit1", 32'(byp_hit1), 1);
    check("t4_data1", byp_data1, 32'd20);
    check("t4_hit2_x0", 32'(byp_hit2), 0);
    check("t4_data2_x0", byp_data2, 32'd0);
    check_port("t4_head", 1'b1, 5'd5, 32'd10);
    rd_addr2 = 5'd7;
    #1;
    check("t4_miss_hit", 32'(byp_hit2), 0);
    check("t4_miss_data", byp_data2, 32'd0);
    step();
    check("t4_after_pop", byp_data1, 32'd20);
    check_port("t4_tail", 1'b1, 5'd5, 32'd20);
    step();
    check("t4_empty", 32'(empty), 1);

    // 3: fill until one slot left; LSU takes the last slot
    drive_lsu(1'b1, 5'd6, 32'd1);
    drive_alu(1'b1, 5'd7, 32'd2);
    step();
    check("t3_count2", 32'(count), 2);
    drive_lsu(1'b1, 5'd8, 32'd3);
    drive_alu(1'b1, 5'd9, 32'd4);
    #1;
    check("t3_both_ready", 32'({lsu_ready, alu_ready}), 32'd3);
    step();
    check("t3_count3", 32'(count), 3);
    check("t3_full", 32'(full), 0);
    check_port("t3_head7", 1'b1, 5'd7, 32'd2);
    drive_lsu(1'b1, 5'd10, 32'd5);
    drive_alu(1'b1, 5'd11, 32'd6);
    #1;
    check("t3_lsu_ready_last", 32'(lsu_ready), 1);
    check("t3_alu_ready_last", 32'(alu_ready), 0);
    step();
    check("t3_count_hold", 32'(count), 3);
    check_port("t3_head8", 1'b1, 5'd8, 32'd3);
    drive_lsu(1'b0, 5'd0, 32'd0);
    #1;
    check("t3_alu_ready_alone", 32'(alu_ready), 1);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    rd_addr1 = 5'd11;
    rd_addr2 = 5'd6;
    #1;
    check("t3_count_alu", 32'(count), 3);
    check_port("t3_head9", 1'b1, 5'd9, 32'd4);
    check("t3_byp_x11", byp_data1, 32'd6);
    check("t3_byp_x6_gone", 32'(byp_hit2), 0);
    step();
    check_port("t3_head10", 1'b1, 5'd10, 32'd5);
    step();
    check_port("t3_head11", 1'b1, 5'd11, 32'd6);
    step();
    check("t3_empty", 32'(empty), 1);

    // 5: x0 write handshakes but is dropped
    drive_alu(1'b1, 5'd0, 32'd123);
    #1;
    check("t5_alu_ready", 32'(alu_ready), 1);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    #1;
    check("t5_count", 32'(count), 0);
    check("t5_we", 32'(RegWriteControl), 0);

    // 6: asynchronous reset with three entries queued
    drive_lsu(1'b1, 5'd12, 32'd100);
    drive_alu(1'b1, 5'd13, 32'd200);
    step();
    drive_lsu(1'b1, 5'd14, 32'd300);
    drive_alu(1'b1, 5'd15, 32'd400);
    step();
    drive_lsu(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    rd_addr1 = 5'd15;
    #1;
    check("t6_count3", 32'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_count", 32'(count), 0);
    check("t6_async_empty", 32'(empty), 1);
    check("t6_async_we", 32'(RegWriteControl), 0);
    check("t6_async_byp", 32'(byp_hit1), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_write", 32'(RegWriteControl), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
